arbitro_dest: RTL and testbench

Round-robin pop arbiter for the two source FIFOs feeding the 2:1 destination mux. Each cycle it drives at most one of pop0/pop1, so the mux forwards one word per pop toward the destination FIFO. It never pops an empty source FIFO and stops popping while the downstream FIFO reports almost-full. Each source may take at most BURST consecutive pops before the grant passes to the other source.

---
 rtl/arbitro_dest_pkg.sv | 18 +
 rtl/arbitro_dest_contador_rafaga.sv | 40 ++++
 rtl/arbitro_dest.sv | 119 +++++++++++
 tb/tb_arbitro_dest.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_dest_pkg.sv
// Shared definitions for the destination pop arbiter: state encodings and parameter defaults.
package arbitro_dest_pkg;

  localparam int unsigned BURST_DEF = 4;
  localparam int unsigned CNT_W_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SERVE0 = 2'b01,
    ST_SERVE1 = 2'b10
  } state_e;

  // Serving state that belongs to a given source index.
  function automatic state_e serve_state(input logic src);
    return src ? ST_SERVE1 : ST_SERVE0;
  endfunction

endpackage

// File: rtl/arbitro_dest_contador_rafaga.sv
// Burst counter: counts pops within the current burst, flags the last pop of a burst.
module contador_rafaga
  import arbitro_dest_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned BURST = BURST_DEF
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Clear wins over increment so a burst end restarts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign tc_c = (cnt_q == CNT_W'(BURST - 1));

endmodule

// File: rtl/arbitro_dest.sv
// Round-robin pop arbiter for the two source FIFOs feeding the destination mux.
module arbitro_dest
  import arbitro_dest_pkg::*;
#(
  parameter int unsigned BURST = BURST_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             fifo_empty0,
  input  logic             fifo_empty1,
  input  logic             afull_dest,
  output logic             pop0,
  output logic             pop1,
  output logic             grant,
  output logic [CNT_W-1:0] burst_cnt,
  output logic             idle
);

  state_e state_d, state_q;
  logic   last_d, last_q;
  logic   grant_d, grant_q;
  logic   idle_d, idle_q;
  logic   cnt_clr, cnt_inc, cnt_tc;
  logic   cur, empty_cur, empty_oth;

  contador_rafaga #(
    .CNT_W (CNT_W),
    .BURST (BURST)
  ) u_contador_rafaga (
    .clk     (clk),
    .reset_L (reset_L),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .cnt     (burst_cnt),
    .tc_c    (cnt_tc)
  );

  // Pops are gated combinationally so afull_dest and empty flags act in the same cycle.
  assign pop0 = (state_q == ST_SERVE0) & ~fifo_empty0 & ~afull_dest;
  assign pop1 = (state_q == ST_SERVE1) & ~fifo_empty1 & ~afull_dest;

  // Next-state, grant and counter control; afull_dest freezes everything.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cur       = (state_q == ST_SERVE1);
    empty_cur = cur ? fifo_empty1 : fifo_empty0;
    empty_oth = cur ? fifo_empty0 : fifo_empty1;

    case (state_q)
      ST_IDLE: begin
        if (!afull_dest) begin
          if (!fifo_empty0 && (fifo_empty1 || last_q)) begin
            state_d = ST_SERVE0;
            grant_d = 1'b0;
            cnt_clr = 1'b1;
          end else if (!fifo_empty1) begin
            state_d = ST_SERVE1;
            grant_d = 1'b1;
            cnt_clr = 1'b1;
          end
        end
      end
      ST_SERVE0, ST_SERVE1: begin
        if (!afull_dest) begin
          if (!empty_cur) begin
            cnt_inc = 1'b1;
            if (cnt_tc) begin
              last_d  = cur;
              cnt_clr = 1'b1;
              if (!empty_oth) begin
                state_d = serve_state(~cur);
                grant_d = ~cur;
              end
            end
          end else begin
            last_d  = cur;
            cnt_clr = 1'b1;
            if (!empty_oth) begin
              state_d = serve_state(~cur);
              grant_d = ~cur;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase

    idle_d = (state_d == ST_IDLE);
  end

  // State, last-served, grant and idle registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      idle_q  <= idle_d;
    end
  end

  assign grant = grant_q;
  assign idle  = idle_q;

endmodule

// File: tb/tb_arbitro_dest.sv
// Testbench for arbitro_dest: behavioural arbiter model, FIFO occupancy model, directed scenarios.
module tb_arbitro_dest;

  localparam int unsigned BURST = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk;
  logic             reset_L;
  logic             fifo_empty0, fifo_empty1, afull_dest;
  logic             pop0, pop1, grant, idle;
  logic [CNT_W-1:0] burst_cnt;

  arbitro_dest #(.BURST(BURST), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .fifo_empty0 (fifo_empty0),
    .fifo_empty1 (fifo_empty1),
    .afull_dest  (afull_dest),
    .pop0        (pop0),
    .pop1        (pop1),
    .grant       (grant),
    .burst_cnt   (burst_cnt),
    .idle        (idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cnt0  = 0;
  int cnt1  = 0;
  int cyc   = 0;
  logic pop0_s = 1'b0;
  logic pop1_s = 1'b0;
  int trace_src[$];
  int trace_cnt[$];
  int trace_cyc[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arbiter model: who owns the grant, how far into the burst, who was served last.
  bit   m_active = 1'b0;
  bit   m_src    = 1'b0;
  int   m_cnt    = 0;
  bit   m_last   = 1'b1;
  logic [1:0] avail;
  assign avail = {~fifo_empty1, ~fifo_empty0};

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      m_active <= 1'b0;
      m_src    <= 1'b0;
      m_cnt    <= 0;
      m_last   <= 1'b1;
    end else if (!afull_dest) begin
      if (!m_active) begin
        if (avail != 2'b00) begin
          m_src    <= (avail == 2'b11) ? ~m_last : avail[1];
          m_active <= 1'b1;
          m_cnt    <= 0;
        end
      end else if (avail[m_src]) begin
        if (m_cnt == int'(BURST) - 1) begin
          m_last <= m_src;
          m_cnt  <= 0;
          if (avail[~m_src]) m_src <= ~m_src;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else begin
        m_last <= m_src;
        m_cnt  <= 0;
        if (avail[~m_src]) m_src <= ~m_src;
        else               m_active <= 1'b0;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle comparison against the model, plus pop trace capture.
  always @(negedge clk) begin
    chk("pop0", int'(pop0), int'(m_active && !m_src && !fifo_empty0 && !afull_dest));
    chk("pop1", int'(pop1), int'(m_active && m_src && !fifo_empty1 && !afull_dest));
    chk("grant", int'(grant), int'(m_src));
    chk("burst_cnt", int'(burst_cnt), m_cnt);
    chk("idle", int'(idle), int'(!m_active));
    chk("pop_exclusive", int'(pop0 & pop1), 0);
    pop0_s <= pop0;
    pop1_s <= pop1;
    if (pop0 || pop1) begin
      trace_src.push_back(pop1 ? 1 : 0);
      trace_cnt.push_back(int'(burst_cnt));
      trace_cyc.push_back(cyc);
    end
  end

  // Advance one cycle; source FIFOs drain by the pop seen in the cycle just ended.
  task automatic step();
    @(posedge clk);
    #1;
    if (pop0_s && cnt0 > 0) cnt0--;
    if (pop1_s && cnt1 > 0) cnt1--;
    fifo_empty0 = (cnt0 == 0);
    fifo_empty1 = (cnt1 == 0);
  endtask

  task automatic set_src(input int n0, input int n1);
    cnt0 = n0;
    cnt1 = n1;
    fifo_empty0 = (cnt0 == 0);
    fifo_empty1 = (cnt1 == 0);
  endtask

  task automatic clear_trace();
    trace_src.delete();
    trace_cnt.delete();
    trace_cyc.delete();
  endtask

  task automatic do_reset();
    step();
    reset_L    = 1'b0;
    afull_dest = 1'b0;
    set_src(0, 0);
    step();
    step();
    reset_L = 1'b1;
    clear_trace();
  endtask

  int t_set;
  int found;
  int exp_src3[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  int exp_cnt2[6]  = '{0, 1, 2, 3, 0, 1};

  initial begin
    reset_L     = 1'b1;
    fifo_empty0 = 1'b1;
    fifo_empty1 = 1'b1;
    afull_dest  = 1'b0;
    #1 reset_L = 1'b0;
    step();
    step();
    reset_L = 1'b1;

    // Both empty after reset: parked in IDLE.
    for (int i = 0; i < 5; i++) step();
    chk("t1_idle", int'(idle), 1);
    chk("t1_pops", int'({pop0, pop1}), 0);
    chk("t1_burst_cnt", int'(burst_cnt), 0);
    chk("t1_grant", int'(grant), 0);

    // Source 0 alone, 6 words: consecutive pops, counter wraps at BURST.
    clear_trace();
    set_src(6, 0);
    t_set = cyc;
    for (int i = 0; i < 12; i++) step();
    chk("t2_npops", trace_src.size(), 6);
    if (trace_src.size() == 6) begin
      chk("t2_latency", trace_cyc[0], t_set + 1);
      chk("t2_contiguous", trace_cyc[5] - trace_cyc[0], 5);
      for (int i = 0; i < 6; i++) begin
        chk("t2_src", trace_src[i], 0);
        chk("t2_cnt", trace_cnt[i], exp_cnt2[i]);
      end
    end
    chk("t2_idle_after", int'(idle), 1);

    // Both sources, 10 words each: 4/4/4 alternation without bubbles.
    do_reset();
    set_src(10, 10);
    for (int i = 0; i < 30; i++) step();
    chk("t3_npops", trace_src.size(), 20);
    if (trace_src.size() >= 12) begin
      for (int i = 0; i < 12; i++) chk("t3_src", trace_src[i], exp_src3[i]);
      chk("t3_no_bubble", trace_cyc[11] - trace_cyc[0], 11);
    end
    chk("t3_idle_after", int'(idle), 1);

    // afull_dest while serving source 0 at burst_cnt=2.
    do_reset();
    set_src(10, 0);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (burst_cnt == 3'd2 && !grant && !idle) found = 1;
    end
    chk("t4_wait", found, 1);
    afull_dest = 1'b1;
    #1 chk("t4_pop_killed", int'(pop0), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_hold_cnt", int'(burst_cnt), 2);
      chk("t4_hold_pop", int'(pop0 | pop1), 0);
    end
    afull_dest = 1'b0;
    #1 chk("t4_resume", int'(pop0), 1);
    chk("t4_resume_cnt", int'(burst_cnt), 2);
    for (int i = 0; i < 15; i++) step();

    // Source 0 empties mid-burst with source 1 waiting: one bubble, then source 1.
    do_reset();
    set_src(2, 5);
    for (int i = 0; i < 8; i++) step();
    chk("t5_npops", trace_src.size() >= 3 ? 1 : 0, 1);
    if (trace_src.size() >= 3) begin
      chk("t5_src0", trace_src[1], 0);
      chk("t5_src1", trace_src[2], 1);
      chk("t5_bubble", trace_cyc[2] - trace_cyc[1], 2);
      chk("t5_cnt", trace_cnt[2], 0);
    end
    for (int i = 0; i < 6; i++) step();

    // Reset pulse mid-burst on source 1, then source 0 wins first.
    do_reset();
    set_src(0, 8);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (burst_cnt == 3'd3 && grant && !idle) found = 1;
    end
    chk("t6_wait", found, 1);
    chk("t6_pop1_before", int'(pop1), 1);
    reset_L = 1'b0;
    set_src(5, cnt1);
    #1;
    chk("t6_pop1_drop", int'(pop1), 0);
    chk("t6_idle", int'(idle), 1);
    chk("t6_cnt", int'(burst_cnt), 0);
    chk("t6_grant", int'(grant), 0);
    step();
    step();
    reset_L = 1'b1;
    clear_trace();
    for (int i = 0; i < 4; i++) step();
    chk("t6_npops", trace_src.size() > 0 ? 1 : 0, 1);
    if (trace_src.size() > 0) chk("t6_first_src", trace_src[0], 0);
    for (int i = 0; i < 20; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
